interrupt_controller: RTL and testbench
=======================================

Name: interrupt_controller

Overview:
- Interrupt source and responder for the processor side of the INT_IRQ / INT_IACK / INT_IEND handshake.
- Generates the periodic frame (timer) interrupt from a clock prescaler.
- Queues keyboard scan codes from the keyboard decoder and presents each one on KBD_KEY with a keyboard interrupt.
- Sits between the keyboard decoder and the active processor (title, game), arbitrates the two sources and enforces one interrupt in service at a time.

Parameters:
- TICK_DIV, 833333, CLK cycles per timer tick (50 MHz / 60 Hz); minimum 4.
- KFIFO_DEPTH, 4, keyboard queue depth in entries; power of two, minimum 2.
- SVC_TIMEOUT, 65535, maximum cycles in SERVICE waiting for INT_IEND before forced release.

Ports:
- CLK  in  1  system clock
- RESET_N  in  1  asynchronous active-low reset
- KBD_VALID  in  1  one-cycle strobe: KBD_CODE holds a new key
- KBD_CODE  in  8  scan code from the keyboard decoder
- INT_IRQ  out  2  00 timer, 01 keyboard, 11 none; 10 is never driven
- INT_IACK  in  1  processor acknowledge, one-cycle pulse
- INT_IEND  in  1  processor end-of-service, one-cycle pulse
- KBD_KEY  out  8  key for the current or last keyboard interrupt
- KBD_OVERFLOW  out  1  sticky: a key was dropped because the queue was full
- TICK_OVERRUN  out  1  sticky: a tick arrived while a timer interrupt was already pending
- SVC_TIMEOUT_ERR  out  1  sticky: service was force-released by the timeout

Behaviour:
- Reset (RESET_N low, asynchronous) sets:
  - INT_IRQ=11, KBD_KEY=00, all sticky flags 0;
  - prescaler=0, queue empty, tickPending=0, FSM=IDLE.
- Reset mid-service abandons the service immediately. The FSM does not wait for INT_IEND.
- Prescaler:
  - counts 0..TICK_DIV-1; at TICK_DIV-1 it wraps and sets tickPending.
  - If tickPending is already 1 at that moment, ticks coalesce (no count) and TICK_OVERRUN is set.
- Keyboard queue:
  - KBD_VALID with the queue not full pushes KBD_CODE.
  - KBD_VALID with the queue full drops the code and sets KBD_OVERFLOW.
  - Push and pop in the same cycle are both honoured; a push on a full queue with a simultaneous pop is accepted.
  - Order is FIFO.
- FSM states: IDLE, ASSERT, SERVICE, RELEASE.
- IDLE:
  - If tickPending: srcTimer=1, clear tickPending, INT_IRQ<=00, go to ASSERT.
  - Else if the queue is not empty: pop, KBD_KEY<=head, INT_IRQ<=01, go to ASSERT.
  - Fixed priority: timer before keyboard.
  - Latency: a pending event at edge N gives INT_IRQ valid after edge N+1.
- ASSERT:
  - INT_IRQ is held stable until INT_IACK.
  - INT_IACK: INT_IRQ<=11, go to SERVICE.
  - INT_IACK and INT_IEND in the same cycle: INT_IRQ<=11, go to RELEASE.
  - INT_IEND alone is ignored.
  - No timeout in ASSERT; the processor may poll indefinitely.
- SERVICE:
  - INT_IRQ=11. The watchdog counts from 0.
  - INT_IEND: go to RELEASE.
  - Watchdog reaches SVC_TIMEOUT: set SVC_TIMEOUT_ERR, go to RELEASE.
  - INT_IACK is ignored.
- RELEASE: one cycle with INT_IRQ=11, then IDLE. This guarantees at least one "none" cycle between services.
- KBD_KEY:
  - changes only on a keyboard selection in IDLE;
  - stays stable through ASSERT, SERVICE and RELEASE;
  - is retained after service and while timer interrupts are served.
- Timer events arriving during any keyboard service, and vice versa, remain pending. None is lost except by coalescing or overflow.
- INT_IACK or INT_IEND while in IDLE is ignored.
- Widths:
  - prescaler width is $clog2(TICK_DIV);
  - watchdog width is $clog2(SVC_TIMEOUT+1);
  - queue pointers are $clog2(KFIFO_DEPTH)+1 bits, with full/empty from MSB compare.
- All outputs are registered.

Decomposition:
- Package int_pkg holds:
  - IRQ code constants IRQ_TIMER=2'b00, IRQ_KBD=2'b01, IRQ_NONE=2'b11;
  - the FSM state enum.
- One sub-module, kbd_fifo:
  - parameterised synchronous FIFO with async active-low reset;
  - ports push/pop/din/dout/full/empty.
- Prescaler, arbiter and FSM live in the top module.

Test Plan:
All scenarios use TICK_DIV=10, SVC_TIMEOUT=16, KFIFO_DEPTH=4.
- Reset: assert RESET_N low mid-cycle -> INT_IRQ=11, KBD_KEY=00, flags 0 immediately; first INT_IRQ=00 appears 10 or 11 cycles after release.
- Timer handshake: wait for INT_IRQ=00, pulse INT_IACK -> INT_IRQ=11 next cycle; INT_IEND 5 cycles later -> one RELEASE cycle, IDLE, no spurious IRQ until the next tick.
- Keyboard: KBD_VALID with code 0x20 while idle -> INT_IRQ=01 and KBD_KEY=0x20 two edges later; KBD_KEY holds 0x20 through IACK/IEND and after.
- Simultaneous tick and key 0x41 -> INT_IRQ=00 served first; after its IEND and a RELEASE cycle, INT_IRQ=01 with KBD_KEY=0x41.
- Overflow: push 0x41..0x45 during a long timer service -> keys 0x41..0x44 delivered in order, 0x45 dropped, KBD_OVERFLOW=1; a missed tick during the long service sets TICK_OVERRUN=1.
- Timeout: INT_IACK with no INT_IEND -> after 16 cycles in SERVICE, SVC_TIMEOUT_ERR=1, RELEASE, then IDLE; the next pending event is presented normally.

Source files
------------

// File: rtl/interrupt_controller_pkg.sv
// Shared IRQ codes and FSM state encoding for the interrupt controller.
package int_pkg;

    localparam logic [1:0] IRQ_TIMER = 2'b00;
    localparam logic [1:0] IRQ_KBD   = 2'b01;
    localparam logic [1:0] IRQ_NONE  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ASSERT  = 2'b01,
        ST_SERVICE = 2'b10,
        ST_RELEASE = 2'b11
    } state_t;

endpackage

// File: rtl/interrupt_controller_if.sv
// Keyboard-decoder and processor handshake signals of the interrupt controller.
interface interrupt_controller_if;

    logic       KBD_VALID;
    logic [7:0] KBD_CODE;
    logic [1:0] INT_IRQ;
    logic       INT_IACK;
    logic       INT_IEND;
    logic [7:0] KBD_KEY;
    logic       KBD_OVERFLOW;
    logic       TICK_OVERRUN;
    logic       SVC_TIMEOUT_ERR;

    // master: keyboard decoder + processor side; slave: the controller
    modport master (
        output KBD_VALID, KBD_CODE, INT_IACK, INT_IEND,
        input  INT_IRQ, KBD_KEY, KBD_OVERFLOW, TICK_OVERRUN, SVC_TIMEOUT_ERR
    );

    modport slave (
        input  KBD_VALID, KBD_CODE, INT_IACK, INT_IEND,
        output INT_IRQ, KBD_KEY, KBD_OVERFLOW, TICK_OVERRUN, SVC_TIMEOUT_ERR
    );

endinterface

// File: rtl/interrupt_controller_kbd_fifo.sv
// Synchronous FIFO for keyboard scan codes; head is visible on dout while not empty.
module kbd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_do_push;
    logic             w_do_pop;

    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop  = pop && !empty;
    // a pop in the same cycle frees the slot the push is about to fill
    assign w_do_push = push && (!full || w_do_pop);
    assign dout      = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// Frame-timer and keyboard interrupt source with IRQ/IACK/IEND handshake,
// fixed timer-over-keyboard priority and a service watchdog.
module interrupt_controller
    import int_pkg::*;
#(
    parameter int TICK_DIV    = 833333,
    parameter int KFIFO_DEPTH = 4,
    parameter int SVC_TIMEOUT = 65535
) (
    input  logic                   CLK,
    input  logic                   RESET_N,
    interrupt_controller_if.slave  bus
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int WW = $clog2(SVC_TIMEOUT + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [WW-1:0] WD_LAST    = WW'(SVC_TIMEOUT - 1);

    logic [PW-1:0] r_presc;
    logic          r_tick_pend;
    state_t        r_state;
    logic [1:0]    r_irq;
    logic [7:0]    r_key;
    logic [WW-1:0] r_wdog;
    logic          r_kbd_ovf;
    logic          r_tick_ovr;
    logic          r_svc_err;

    logic          w_tick;
    logic          w_fifo_full;
    logic          w_fifo_empty;
    logic [7:0]    w_fifo_head;
    logic          w_pop;
    logic          w_take_tick;
    logic          w_timeout;
    state_t        w_state_nxt;
    logic [1:0]    w_irq_nxt;
    logic [7:0]    w_key_nxt;
    logic [WW-1:0] w_wdog_nxt;

    kbd_fifo #(
        .DEPTH (KFIFO_DEPTH),
        .WIDTH (8)
    ) u_kbd_fifo (
        .clk   (CLK),
        .rst_n (RESET_N),
        .push  (bus.KBD_VALID),
        .pop   (w_pop),
        .din   (bus.KBD_CODE),
        .dout  (w_fifo_head),
        .full  (w_fifo_full),
        .empty (w_fifo_empty)
    );

    assign w_tick = (r_presc == PRESC_LAST);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    // a new tick wins over a same-cycle consume, so it is not lost
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_tick_pend <= 1'b0;
        end else if (w_tick) begin
            r_tick_pend <= 1'b1;
        end else if (w_take_tick) begin
            r_tick_pend <= 1'b0;
        end else begin
            r_tick_pend <= r_tick_pend;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_kbd_ovf  <= 1'b0;
            r_tick_ovr <= 1'b0;
            r_svc_err  <= 1'b0;
        end else begin
            if (bus.KBD_VALID && w_fifo_full && !w_pop)   r_kbd_ovf  <= 1'b1;
            if (w_tick && r_tick_pend && !w_take_tick)    r_tick_ovr <= 1'b1;
            if (w_timeout)                                r_svc_err  <= 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_irq_nxt   = r_irq;
        w_key_nxt   = r_key;
        w_wdog_nxt  = r_wdog;
        w_pop       = 1'b0;
        w_take_tick = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_tick_pend) begin
                    w_take_tick = 1'b1;
                    w_irq_nxt   = IRQ_TIMER;
                    w_state_nxt = ST_ASSERT;
                end else if (!w_fifo_empty) begin
                    w_pop       = 1'b1;
                    w_key_nxt   = w_fifo_head;
                    w_irq_nxt   = IRQ_KBD;
                    w_state_nxt = ST_ASSERT;
                end else begin
                    w_irq_nxt   = IRQ_NONE;
                end
            end
            ST_ASSERT: begin
                if (bus.INT_IACK) begin
                    w_irq_nxt   = IRQ_NONE;
                    w_wdog_nxt  = '0;
                    w_state_nxt = bus.INT_IEND ? ST_RELEASE : ST_SERVICE;
                end else begin
                    w_state_nxt = ST_ASSERT;
                end
            end
            ST_SERVICE: begin
                w_irq_nxt = IRQ_NONE;
                if (bus.INT_IEND) begin
                    w_state_nxt = ST_RELEASE;
                end else if (r_wdog == WD_LAST) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = ST_RELEASE;
                end else begin
                    w_wdog_nxt  = r_wdog + WW'(1);
                end
            end
            ST_RELEASE: begin
                w_irq_nxt   = IRQ_NONE;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_irq_nxt   = IRQ_NONE;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= ST_IDLE;
            r_irq   <= IRQ_NONE;
            r_key   <= 8'h00;
            r_wdog  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_irq   <= w_irq_nxt;
            r_key   <= w_key_nxt;
            r_wdog  <= w_wdog_nxt;
        end
    end

    assign bus.INT_IRQ         = r_irq;
    assign bus.KBD_KEY         = r_key;
    assign bus.KBD_OVERFLOW    = r_kbd_ovf;
    assign bus.TICK_OVERRUN    = r_tick_ovr;
    assign bus.SVC_TIMEOUT_ERR = r_svc_err;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed scoreboard bench: stimulus pushes expected IRQ presentations, a monitor pops and compares.
module tb_interrupt_controller;
    import int_pkg::*;

    localparam int TICK_DIV    = 10;
    localparam int SVC_TIMEOUT = 16;
    localparam int KFIFO_DEPTH = 4;

    typedef struct packed {
        logic [1:0] irq;
        logic [7:0] key;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   cyc;
    int   checks   = 0;
    int   failures = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    interrupt_controller_if bus_if();

    interrupt_controller #(
        .TICK_DIV    (TICK_DIV),
        .KFIFO_DEPTH (KFIFO_DEPTH),
        .SVC_TIMEOUT (SVC_TIMEOUT)
    ) dut (
        .CLK     (clk),
        .RESET_N (rst_n),
        .bus     (bus_if)
    );

    // cycle count since reset release: after the k-th rising edge cyc == k
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t cyc=%0d)", name, act, exp, $time, cyc);
        end
    endtask

    task automatic push_exp(input logic [1:0] irq, input logic [7:0] key);
        exp_t e;
        e.irq = irq;
        e.key = key;
        sb_q.push_back(e);
    endtask

    // monitor: each fresh IRQ presentation is compared against the scoreboard head
    initial begin
        logic [1:0] prev_irq;
        exp_t       e;
        prev_irq = IRQ_NONE;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_irq = IRQ_NONE;
            end else begin
                if (bus_if.INT_IRQ == 2'b10) begin
                    checks++; failures++;
                    $display("FAIL irq_code actual=%b required=not 10", bus_if.INT_IRQ);
                end
                if (bus_if.INT_IRQ != IRQ_NONE && prev_irq == IRQ_NONE) begin
                    if (sb_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL spurious_irq actual=%b key=0x%h required=none (cyc=%0d)", bus_if.INT_IRQ, bus_if.KBD_KEY, cyc);
                    end else begin
                        e = sb_q.pop_front();
                        check("sb_irq", {30'd0, bus_if.INT_IRQ}, {30'd0, e.irq});
                        check("sb_key", {24'd0, bus_if.KBD_KEY}, {24'd0, e.key});
                    end
                end else if (bus_if.INT_IRQ != IRQ_NONE && bus_if.INT_IRQ != prev_irq) begin
                    checks++; failures++;
                    $display("FAIL irq_stable actual=%b required=%b", bus_if.INT_IRQ, prev_irq);
                end
                prev_irq = bus_if.INT_IRQ;
            end
        end
    end

    task automatic wait_irq(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (bus_if.INT_IRQ == IRQ_NONE && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (bus_if.INT_IRQ == IRQ_NONE) begin
            checks++; failures++;
            $display("FAIL %s actual=no_irq required=irq within 200 cycles", name);
        end
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // acknowledge on the presenting cycle, end service on the next one
    task automatic service(input string name);
        wait_irq(name);
        bus_if.INT_IACK = 1'b1;
        @(negedge clk);
        bus_if.INT_IACK = 1'b0;
        bus_if.INT_IEND = 1'b1;
        @(negedge clk);
        bus_if.INT_IEND = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_irq"},  {30'd0, bus_if.INT_IRQ}, {30'd0, IRQ_NONE});
        check({tag, "_key"},  {24'd0, bus_if.KBD_KEY}, 32'h0000_0000);
        check({tag, "_ovf"},  {31'd0, bus_if.KBD_OVERFLOW}, 32'd0);
        check({tag, "_ovr"},  {31'd0, bus_if.TICK_OVERRUN}, 32'd0);
        check({tag, "_serr"}, {31'd0, bus_if.SVC_TIMEOUT_ERR}, 32'd0);
    endtask

    initial begin
        bus_if.KBD_VALID = 1'b0;
        bus_if.KBD_CODE  = 8'h00;
        bus_if.INT_IACK  = 1'b0;
        bus_if.INT_IEND  = 1'b0;

        #3 rst_n = 1'b0;
        #1 check_reset_state("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // first tick and a slow handshake
        push_exp(IRQ_TIMER, 8'h00);
        wait_irq("first_tick");
        check("first_tick_latency", {31'd0, (cyc == 10 || cyc == 11)}, 32'd1);
        bus_if.INT_IACK = 1'b1;
        @(negedge clk);
        bus_if.INT_IACK = 1'b0;
        check("iack_clears_irq", {30'd0, bus_if.INT_IRQ}, {30'd0, IRQ_NONE});
        repeat (4) @(negedge clk);
        bus_if.INT_IEND = 1'b1;
        @(negedge clk);
        bus_if.INT_IEND = 1'b0;
        check("release_irq_none", {30'd0, bus_if.INT_IRQ}, {30'd0, IRQ_NONE});
        @(negedge clk);
        check("idle_irq_none", {30'd0, bus_if.INT_IRQ}, {30'd0, IRQ_NONE});

        // second tick, then key 0x20 while idle
        push_exp(IRQ_TIMER, 8'h00);
        service("tick2");
        wait_cyc(24);
        push_exp(IRQ_KBD, 8'h20);
        bus_if.KBD_VALID = 1'b1;
        bus_if.KBD_CODE  = 8'h20;
        @(negedge clk);
        bus_if.KBD_VALID = 1'b0;
        wait_irq("kbd_20");
        check("kbd_latency", cyc, 32'd26);
        bus_if.INT_IACK = 1'b1;
        @(negedge clk);
        bus_if.INT_IACK = 1'b0;
        check("key_in_service", {24'd0, bus_if.KBD_KEY}, 32'h20);
        bus_if.INT_IEND = 1'b1;
        @(negedge clk);
        bus_if.INT_IEND = 1'b0;
        check("key_at_release", {24'd0, bus_if.KBD_KEY}, 32'h20);

        // timer service keeps the last key
        push_exp(IRQ_TIMER, 8'h20);
        service("tick3");

        // tick and key 0x41 land on the same edge: timer first
        wait_cyc(39);
        push_exp(IRQ_TIMER, 8'h20);
        push_exp(IRQ_KBD, 8'h41);
        bus_if.KBD_VALID = 1'b1;
        bus_if.KBD_CODE  = 8'h41;
        @(negedge clk);
        bus_if.KBD_VALID = 1'b0;
        service("simul_tick");
        service("simul_kbd");

        // long ASSERT: five keys into a depth-4 queue, missed tick
        push_exp(IRQ_TIMER, 8'h41);
        wait_irq("long_tick");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus_if.KBD_VALID = 1'b1;
            bus_if.KBD_CODE  = 8'h41 + 8'(i);
        end
        @(negedge clk);
        bus_if.KBD_VALID = 1'b0;
        check("kbd_overflow_set", {31'd0, bus_if.KBD_OVERFLOW}, 32'd1);
        wait_cyc(69);
        check("overrun_not_yet", {31'd0, bus_if.TICK_OVERRUN}, 32'd0);
        wait_cyc(71);
        check("overrun_set", {31'd0, bus_if.TICK_OVERRUN}, 32'd1);
        bus_if.INT_IACK = 1'b1;
        @(negedge clk);
        bus_if.INT_IACK = 1'b0;
        bus_if.INT_IEND = 1'b1;
        @(negedge clk);
        bus_if.INT_IEND = 1'b0;

        push_exp(IRQ_TIMER, 8'h41);
        push_exp(IRQ_KBD,   8'h41);
        push_exp(IRQ_TIMER, 8'h41);
        push_exp(IRQ_KBD,   8'h42);
        push_exp(IRQ_TIMER, 8'h42);
        push_exp(IRQ_KBD,   8'h43);
        push_exp(IRQ_KBD,   8'h44);
        push_exp(IRQ_TIMER, 8'h44);
        for (int i = 0; i < 8; i++) service("drain");

        // watchdog: acknowledge and never end service
        push_exp(IRQ_TIMER, 8'h44);
        wait_irq("wd_tick");
        bus_if.INT_IACK = 1'b1;
        @(negedge clk);
        bus_if.INT_IACK = 1'b0;
        wait_cyc(127);
        check("svc_err_not_yet", {31'd0, bus_if.SVC_TIMEOUT_ERR}, 32'd0);
        wait_cyc(128);
        check("svc_err_set", {31'd0, bus_if.SVC_TIMEOUT_ERR}, 32'd1);

        push_exp(IRQ_TIMER, 8'h44);
        wait_irq("post_timeout");
        check("post_timeout_cyc", cyc, 32'd130);

        // reset in the middle of a service
        bus_if.INT_IACK = 1'b1;
        @(negedge clk);
        bus_if.INT_IACK = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_reset_state("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        push_exp(IRQ_TIMER, 8'h00);
        wait_irq("after_midreset");
        check("midreset_tick_latency", {31'd0, (cyc == 10 || cyc == 11)}, 32'd1);

        @(negedge clk);
        check("scoreboard_drained", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
